// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Execute-issue stage sitting directly in front of the ALU. It accepts a
// decoded register-read bundle (instruction word plus rs1/rs2 values) over a
// valid/ready handshake. It translates RV32IM R-type and I-type ALU
// instructions into the ALU's one-hot operation select and its two operands.
// The result is presented through a two-entry (main + skid) buffer, so the ALU
// side can stall without losing or duplicating bundles.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   in_valid         upstream bundle valid
//   in_ready         stage can accept (registered, equals "skid entry empty")
//   instr            RV32 instruction word
//   rs1_data         source register 1 value
//   rs2_data         source register 2 value
//   flush            synchronous pipeline kill (clears both entries)
//   out_valid        ALU bundle valid
//   out_ready        downstream accepts
//   alu_in1          operand 1 (always rs1_data)
//   alu_in2          operand 2 (rs2_data, sign-extended imm, or shift amount)
//   alu_instructions one-hot ALU op select, zero for illegal bundles
//   rd               destination register index
//   illegal          bundle carries an undecodable instruction
//   illegal_count    saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int OP_W  = 13,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [OP_W-1:0]  alu_instructions,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    // One buffered ALU bundle.
    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [OP_W-1:0] op;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    localparam int      BUNDLE_W    = $bits(bundle_t);
    localparam bundle_t BUNDLE_ZERO = bundle_t'({BUNDLE_W{1'b0}});

    // Opcodes and funct7 encodings recognised by the decoder.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // One-hot ALU operation select values.
    localparam logic [OP_W-1:0] OP_NONE = 13'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 13'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 13'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 13'd4;
    localparam logic [OP_W-1:0] OP_OR   = 13'd8;
    localparam logic [OP_W-1:0] OP_AND  = 13'd16;
    localparam logic [OP_W-1:0] OP_SLL  = 13'd32;
    localparam logic [OP_W-1:0] OP_SRL  = 13'd64;
    localparam logic [OP_W-1:0] OP_SRA  = 13'd128;
    localparam logic [OP_W-1:0] OP_SLT  = 13'd256;
    localparam logic [OP_W-1:0] OP_SLTU = 13'd512;
    localparam logic [OP_W-1:0] OP_MUL  = 13'd1024;
    localparam logic [OP_W-1:0] OP_DIV  = 13'd2048;
    localparam logic [OP_W-1:0] OP_REM  = 13'd4096;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Instruction fields.
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] shamt_s;
    logic [4:0]      unused_rs1_field_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign imm_i_s  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign shamt_s  = {{(XLEN-5){1'b0}}, instr[24:20]};
    // The rs1 index was already used by the register-file read upstream.
    assign unused_rs1_field_s = instr[19:15];

    // State: main (output) entry, skid entry, ready flag, illegal counter.
    bundle_t          main_q, main_d;
    bundle_t          skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    bundle_t dec_s;
    logic    acc_s;
    logic    pop_s;

    // Decode the incoming instruction into an ALU bundle.
    always_comb begin
        dec_s.in1     = rs1_data;
        dec_s.in2     = rs2_data;
        dec_s.op      = OP_NONE;
        dec_s.rd      = instr[11:7];
        dec_s.illegal = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                dec_s.in2 = rs2_data;
                case ({funct7_s, funct3_s})
                    {F7_BASE,   3'b000}: dec_s.op = OP_ADD;
                    {F7_BASE,   3'b001}: dec_s.op = OP_SLL;
                    {F7_BASE,   3'b010}: dec_s.op = OP_SLT;
                    {F7_BASE,   3'b011}: dec_s.op = OP_SLTU;
                    {F7_BASE,   3'b100}: dec_s.op = OP_XOR;
                    {F7_BASE,   3'b101}: dec_s.op = OP_SRL;
                    {F7_BASE,   3'b110}: dec_s.op = OP_OR;
                    {F7_BASE,   3'b111}: dec_s.op = OP_AND;
                    {F7_ALT,    3'b000}: dec_s.op = OP_SUB;
                    {F7_ALT,    3'b101}: dec_s.op = OP_SRA;
                    {F7_MULDIV, 3'b000}: dec_s.op = OP_MUL;
                    {F7_MULDIV, 3'b100}: dec_s.op = OP_DIV;
                    {F7_MULDIV, 3'b110}: dec_s.op = OP_REM;
                    default:             dec_s.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_s.in2 = imm_i_s;
                case (funct3_s)
                    3'b000: dec_s.op = OP_ADD;
                    3'b010: dec_s.op = OP_SLT;
                    3'b011: dec_s.op = OP_SLTU;
                    3'b100: dec_s.op = OP_XOR;
                    3'b110: dec_s.op = OP_OR;
                    3'b111: dec_s.op = OP_AND;
                    3'b001: begin
                        // Shifts take only the 5-bit shamt; upper bits select the variant.
                        dec_s.in2 = shamt_s;
                        if (funct7_s == F7_BASE) begin
                            dec_s.op = OP_SLL;
                        end else begin
                            dec_s.illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        dec_s.in2 = shamt_s;
                        if (funct7_s == F7_BASE) begin
                            dec_s.op = OP_SRL;
                        end else if (funct7_s == F7_ALT) begin
                            dec_s.op = OP_SRA;
                        end else begin
                            dec_s.illegal = 1'b1;
                        end
                    end
                    default: dec_s.illegal = 1'b1;
                endcase
            end
            default: dec_s.illegal = 1'b1;
        endcase
    end

    // A bundle presented alongside flush is never accepted.
    assign acc_s = in_valid & in_ready_q & ~flush;
    assign pop_s = main_valid_q & out_ready;

    // Main/skid buffer next state.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_d       = BUNDLE_ZERO;
            skid_d       = BUNDLE_ZERO;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop_s) begin
            if (skid_valid_q) begin
                // Skid drains into main; in_ready was low, so nothing new arrives.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (acc_s) begin
                main_d       = dec_s;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!main_valid_q) begin
            if (acc_s) begin
                main_d       = dec_s;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else begin
            // Main is stalled: an accepted bundle parks in the skid entry.
            if (acc_s) begin
                skid_d       = dec_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // Saturating illegal-instruction counter; flush does not clear it.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_s && dec_s.illegal) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= BUNDLE_ZERO;
            skid_q       <= BUNDLE_ZERO;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = main_valid_q;
    assign alu_in1          = main_q.in1;
    assign alu_in2          = main_q.in2;
    assign alu_instructions = main_q.op;
    assign rd               = main_q.rd;
    assign illegal          = main_q.illegal;
    assign illegal_count    = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Table of directed decode vectors with hand-computed expected outputs, plus
// hand-written sequences for backpressure, flush, mid-stream reset and
// illegal-counter saturation.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [12:0] alu_instructions;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] illegal_count;

    int total;
    int bad;
    int exp_cnt;

    alu_issue_stage dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instr            (instr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .alu_in1          (alu_in1),
        .alu_in2          (alu_in2),
        .alu_instructions (alu_instructions),
        .rd               (rd),
        .illegal          (illegal),
        .illegal_count    (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records alu_in1 of every output handshake while enabled.
    logic        mon_en;
    logic [31:0] seen[$];
    always @(posedge clk) begin
        if (mon_en && out_valid && out_ready) seen.push_back(alu_in1);
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] in2;
        logic [12:0] op;
        logic [4:0]  rd;
        logic        ill;
        logic        chk_in2;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, r1, f3, d, 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_cnt   = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // ---------------- vector table ----------------
        vecs.push_back('{32'h002081B3, 32'd5, 32'd7, 32'd7, 13'd1, 5'd3, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1), 32'd100, 32'd30, 32'd30, 13'd2, 5'd1, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000000, 5'd4, 5'd5, 3'b001, 5'd6), 32'h11, 32'h4, 32'h4, 13'd32, 5'd6, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000000, 5'd4, 5'd5, 3'b010, 5'd7), 32'h12, 32'h5, 32'h5, 13'd256, 5'd7, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000000, 5'd4, 5'd5, 3'b011, 5'd8), 32'h13, 32'h6, 32'h6, 13'd512, 5'd8, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000000, 5'd4, 5'd5, 3'b100, 5'd9), 32'h14, 32'h7, 32'h7, 13'd4, 5'd9, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000000, 5'd4, 5'd5, 3'b101, 5'd10), 32'h15, 32'h8, 32'h8, 13'd64, 5'd10, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000000, 5'd4, 5'd5, 3'b110, 5'd11), 32'h16, 32'h9, 32'h9, 13'd8, 5'd11, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000000, 5'd4, 5'd5, 3'b111, 5'd12), 32'h17, 32'hA, 32'hA, 13'd16, 5'd12, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0100000, 5'd4, 5'd5, 3'b101, 5'd13), 32'h18, 32'hB, 32'hB, 13'd128, 5'd13, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000001, 5'd4, 5'd5, 3'b000, 5'd14), 32'h19, 32'hC, 32'hC, 13'd1024, 5'd14, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000001, 5'd4, 5'd5, 3'b100, 5'd15), 32'h1A, 32'hD, 32'hD, 13'd2048, 5'd15, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'b0000001, 5'd4, 5'd5, 3'b110, 5'd16), 32'h1B, 32'hE, 32'hE, 13'd4096, 5'd16, 1'b0, 1'b1});
        vecs.push_back('{32'h021090B3, 32'h21, 32'h22, 32'h22, 13'd0, 5'd1, 1'b1, 1'b1});
        vecs.push_back('{enc_r(7'b0100000, 5'd4, 5'd5, 3'b001, 5'd17), 32'h23, 32'h24, 32'h24, 13'd0, 5'd17, 1'b1, 1'b1});
        vecs.push_back('{enc_r(7'b0000010, 5'd4, 5'd5, 3'b000, 5'd18), 32'h25, 32'h26, 32'h26, 13'd0, 5'd18, 1'b1, 1'b1});
        vecs.push_back('{32'hFFF00293, 32'd0, 32'h99, 32'hFFFF_FFFF, 13'd1, 5'd5, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'h7FF, 5'd1, 3'b010, 5'd19), 32'h31, 32'h99, 32'h0000_07FF, 13'd256, 5'd19, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'h800, 5'd1, 3'b011, 5'd20), 32'h32, 32'h99, 32'hFFFF_F800, 13'd512, 5'd20, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'hABC, 5'd1, 3'b100, 5'd21), 32'h33, 32'h99, 32'hFFFF_FABC, 13'd4, 5'd21, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'h123, 5'd1, 3'b110, 5'd22), 32'h34, 32'h99, 32'h0000_0123, 13'd8, 5'd22, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'hF0F, 5'd1, 3'b111, 5'd23), 32'h35, 32'h99, 32'hFFFF_FF0F, 13'd16, 5'd23, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'h01F, 5'd1, 3'b001, 5'd24), 32'h36, 32'h99, 32'd31, 13'd32, 5'd24, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'h00A, 5'd1, 3'b101, 5'd25), 32'h37, 32'h99, 32'd10, 13'd64, 5'd25, 1'b0, 1'b1});
        vecs.push_back('{32'h4040D313, 32'h8000_0000, 32'h99, 32'd4, 13'd128, 5'd6, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'h405, 5'd1, 3'b001, 5'd26), 32'h38, 32'h99, 32'd0, 13'd0, 5'd26, 1'b1, 1'b0});
        vecs.push_back('{enc_i(12'h205, 5'd1, 3'b101, 5'd27), 32'h39, 32'h99, 32'd0, 13'd0, 5'd27, 1'b1, 1'b0});
        vecs.push_back('{32'h0000A103, 32'h3A, 32'h99, 32'd0, 13'd0, 5'd2, 1'b1, 1'b0});

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_in2", alu_in2, 32'd0);
        check("rst_op", 32'(alu_instructions), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_count", 32'(illegal_count), 32'd0);
        rst = 1'b0;

        // ---------------- decode table, one bundle per transfer ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            instr     = vecs[i].instr;
            rs1_data  = vecs[i].rs1;
            rs2_data  = vecs[i].rs2;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (vecs[i].ill) exp_cnt++;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_in1", i), alu_in1, vecs[i].rs1);
            if (vecs[i].chk_in2) check($sformatf("vec%0d_in2", i), alu_in2, vecs[i].in2);
            check($sformatf("vec%0d_op", i), 32'(alu_instructions), 32'(vecs[i].op));
            check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
            check($sformatf("vec%0d_count", i), 32'(illegal_count), 32'(exp_cnt));
        end

        // ---------------- backpressure: A, B, C with stalled ALU ----------------
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);
        seen.delete();
        mon_en    = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        rs2_data  = 32'd1;
        rs1_data  = 32'h111;
        @(negedge clk);
        check("bp_ready_after_a", 32'(in_ready), 32'd1);
        check("bp_a_on_out", alu_in1, 32'h111);
        rs1_data = 32'h222;
        @(negedge clk);
        check("bp_ready_after_b", 32'(in_ready), 32'd0);
        check("bp_a_held", alu_in1, 32'h111);
        rs1_data = 32'h333;
        repeat (2) @(negedge clk);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_in1", alu_in1, 32'h111);
        check("bp_stall_op", 32'(alu_instructions), 32'd1);
        check("bp_stall_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b_out", alu_in1, 32'h222);
        check("bp_ready_reopen", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_c_out", alu_in1, 32'h333);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);
        mon_en = 1'b0;
        check("bp_deliveries", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("bp_order0", seen[0], 32'h111);
            check("bp_order1", seen[1], 32'h222);
            check("bp_order2", seen[2], 32'h333);
        end

        // ---------------- flush with main+skid full ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        rs1_data  = 32'hA1;
        @(negedge clk);
        rs1_data = 32'hB2;
        @(negedge clk);
        check("fl_full_ready", 32'(in_ready), 32'd0);
        instr    = 32'h021090B3;
        rs1_data = 32'hC3;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        check("fl_count", 32'(illegal_count), 32'(exp_cnt));
        seen.delete();
        mon_en    = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("fl_nothing_out", 32'(seen.size()), 32'd0);

        // ---------------- flush while ready: presented bundle discarded ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        rs1_data  = 32'hD4;
        @(negedge clk);
        check("fl2_ready", 32'(in_ready), 32'd1);
        instr    = 32'h021090B3;
        rs1_data = 32'hE5;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", 32'(out_valid), 32'd0);
        check("fl2_count", 32'(illegal_count), 32'(exp_cnt));
        seen.delete();
        mon_en    = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("fl2_nothing_out", 32'(seen.size()), 32'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h021090B3;
        rs1_data  = 32'hF6;
        @(negedge clk);
        exp_cnt++;
        instr    = 32'h002081B3;
        rs1_data = 32'hF7;
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_full_ready", 32'(in_ready), 32'd0);
        check("mr_pre_count", 32'(illegal_count), 32'(exp_cnt));
        #1 rst = 1'b1;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_ready", 32'(in_ready), 32'd1);
        check("mr_count", 32'(illegal_count), 32'd0);
        check("mr_in1", alu_in1, 32'd0);
        check("mr_op", 32'(alu_instructions), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;

        // ---------------- illegal counter saturation ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h021090B3;
        rs1_data  = 32'h5A;
        repeat (65534) @(negedge clk);
        check("sat_fffe", 32'(illegal_count), 32'h0000_FFFE);
        @(negedge clk);
        check("sat_ffff", 32'(illegal_count), 32'h0000_FFFF);
        repeat (3) @(negedge clk);
        check("sat_hold", 32'(illegal_count), 32'h0000_FFFF);
        check("sat_illegal", 32'(illegal), 32'd1);
        check("sat_op", 32'(alu_instructions), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the ALU.
- Accepts a decoded-register-read bundle (instruction word plus rs1/rs2 data) over a valid/ready handshake.
- Translates RV32IM R-type and I-type ALU instructions into the ALU's 13-bit one-hot operation select and its two 32-bit operands.
- Presents the result through a 2-entry skid buffer, so the ALU side can stall without losing or duplicating instructions.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- OP_W, 13, width of the one-hot ALU operation select.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
- instr  in  32  RV32 instruction word.
- rs1_data  in  32  source register 1 value.
- rs2_data  in  32  source register 2 value.
- flush  in  1  synchronous pipeline kill.
- out_valid  out  1  ALU bundle valid.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid && out_ready.
- alu_in1  out  32  operand 1.
- alu_in2  out  32  operand 2.
- alu_instructions  out  13  one-hot op select; 0 means no-op / illegal.
- rd  out  5  destination register (instr[11:7]).
- illegal  out  1  bundle carries an undecodable instruction.
- illegal_count  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (async, rst=1): out_valid=0, in_ready=1, alu_in1=alu_in2=0, alu_instructions=0, rd=0, illegal=0, illegal_count=0, both buffer entries empty.
- Decode, opcode 0110011 (R-type), in2=rs2_data:
  - funct7 0000000: f3 000 add=1, 001 sll=32, 010 slt=256, 011 sltu=512, 100 xor=4, 101 srl=64, 110 or=8, 111 and=16.
  - funct7 0100000: f3 000 sub=2, 101 sra=128.
  - funct7 0000001: f3 000 mul=1024, 100 div=2048, 110 rem=4096.
  - Any other funct7/funct3 combination is illegal.
- Decode, opcode 0010011 (I-type):
  - addi=1, slti=256, sltiu=512, xori=4, ori=8, andi=16; in2 = sign-extended instr[31:20].
  - slli (funct7 0000000)=32, srli (0000000)=64, srai (0100000)=128; in2 = zero-extended instr[24:20].
  - Any other funct7 on a shift is illegal.
- Decode, all cases: in1=rs1_data. Any other opcode is illegal.
- Illegal bundle: alu_instructions=0, illegal=1, operands still passed. It flows through the buffer like a legal bundle. illegal_count increments on acceptance and saturates at all-ones.
- Latency: a bundle accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1 when the output entry is empty or draining.
- Buffer: main (output) entry plus skid entry.
  - Accept with main empty, or main full and out_ready=1: load main.
  - Accept with main full and out_ready=0: load skid; in_ready=0 from the next cycle.
  - out_ready=1 with skid full: main<=skid, skid empties, in_ready=1 next cycle.
  - in_ready is registered and equals "skid empty"; it is never combinationally dependent on out_ready.
- Stability: while out_valid=1 and out_ready=0, all output fields hold unchanged.
- Ordering: strict FIFO; no drops or duplicates except on flush.
- Flush:
  - Next cycle: both entries are cleared, out_valid=0, in_ready=1.
  - A bundle presented in the same cycle as flush is discarded and not counted.
  - illegal_count is not cleared by flush.
- Reset mid-operation: outputs return to reset values immediately (asynchronous); buffered bundles are lost.

Test Plan:
- Reset: assert rst mid-stream with both entries full -> out_valid=0, in_ready=1, illegal_count=0 immediately, before the next clock edge.
- add x3,x1,x2: instr=0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_in1=5, alu_in2=7, alu_instructions=13'd1, rd=3, illegal=0.
- Immediates:
  - addi x5,x0,-1 (0xFFF00293) -> alu_in2=32'hFFFF_FFFF, op=1, rd=5.
  - srai x6,x1,4 (0x4040D313) -> alu_in2=4, op=128, rd=6.
- Backpressure:
  - Setup: out_ready=0; send bundles A, B, C back to back.
  - Expected while stalled: A on outputs, B in skid, in_ready=0 after B, C held upstream.
  - Release: raise out_ready -> A, B, C delivered in order on consecutive accepts, each exactly once.
- Illegal: mulh (0x021090B3) -> op=0, illegal=1, illegal_count 0->1. Preload the counter path to 16'hFFFF with repeated illegals -> count stays 16'hFFFF.
- Flush: with main+skid full and in_valid=1, pulse flush -> next cycle out_valid=0, in_ready=1, the presented bundle never appears, illegal_count unchanged.
